// File: rtl/checkbits_pkg.sv
// checkbits_pkg: shared types and default marks for the checkbits monitor.
// Provides the run-state enum and the default start/finish mark values.
package checkbits_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [15:0] DEF_START_MARK  = 16'hA5A5;
    localparam logic [15:0] DEF_FINISH_MARK = 16'h5A5A;

endpackage

// File: rtl/checkbits_filter.sv
// checkbits_filter: two-flop synchroniser plus stability filter.
// Ports: clk, rst (sync, active-high), check_in (async raw bus),
//        value (debounced accepted value), accept (one-cycle new-value strobe).
module checkbits_filter
    import checkbits_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] check_in,
    output logic [WIDTH-1:0] value,
    output logic             accept
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] cand_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             take;

    // The accept decision uses the post-update candidate and count so that
    // STABLE_CYCLES=1 accepts on the first synchronised sample.
    always_comb begin
        cand_next = cand;
        cnt_next  = cnt;
        if (s2 != cand) begin
            cand_next = s2;
            cnt_next  = CW'(1);
        end else if (cnt < CW'(STABLE_CYCLES)) begin
            cnt_next = cnt + CW'(1);
        end
        take = (cnt_next == CW'(STABLE_CYCLES)) && (cand_next != value);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            cand   <= '0;
            cnt    <= '0;
            value  <= '0;
            accept <= 1'b0;
        end else begin
            s1     <= check_in;
            s2     <= s1;
            cand   <= cand_next;
            cnt    <= cnt_next;
            accept <= take;
            if (take) begin
                value <= cand_next;
            end
        end
    end

endmodule

// File: rtl/checkbits_monitor.sv
// checkbits_monitor: debounced start/finish run monitor with counters.
// Ports: clk, rst, check_in, clear -> state, done_pulse, error,
//        cycle_count, change_count, value.
module checkbits_monitor
    import checkbits_pkg::*;
#(
    parameter int               WIDTH         = 16,
    parameter logic [WIDTH-1:0] START_MARK    = DEF_START_MARK,
    parameter logic [WIDTH-1:0] FINISH_MARK   = DEF_FINISH_MARK,
    parameter int               STABLE_CYCLES = 2,
    parameter int               CNT_W         = 32,
    parameter int unsigned      TIMEOUT       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] check_in,
    input  logic             clear,
    output logic [1:0]       state,
    output logic             done_pulse,
    output logic             error,
    output logic [CNT_W-1:0] cycle_count,
    output logic [15:0]      change_count,
    output logic [WIDTH-1:0] value
);

    if (START_MARK == FINISH_MARK) begin : g_bad_marks
        $error("checkbits_monitor: START_MARK must differ from FINISH_MARK");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("checkbits_monitor: STABLE_CYCLES must be at least 1");
    end

    logic accept;

    checkbits_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .check_in (check_in),
        .value    (value),
        .accept   (accept)
    );

    state_t           cur_state;
    state_t           next_state;
    logic [CNT_W-1:0] cyc_next;
    logic [CNT_W-1:0] cyc_inc;
    logic [15:0]      chg_next;
    logic [15:0]      chg_inc;
    logic             err_next;
    logic             pulse_next;
    logic             is_start;
    logic             is_finish;
    logic             hit_limit;

    assign state = cur_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state    <= ST_IDLE;
            cycle_count  <= '0;
            change_count <= '0;
            error        <= 1'b0;
            done_pulse   <= 1'b0;
        end else begin
            cur_state    <= next_state;
            cycle_count  <= cyc_next;
            change_count <= chg_next;
            error        <= err_next;
            done_pulse   <= pulse_next;
        end
    end

    always_comb begin
        next_state = cur_state;
        cyc_next   = cycle_count;
        chg_next   = change_count;
        err_next   = error;
        pulse_next = 1'b0;

        is_start  = accept && (value == START_MARK);
        is_finish = accept && (value == FINISH_MARK);
        cyc_inc   = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
        chg_inc   = (&change_count) ? change_count : change_count + 16'd1;
        hit_limit = (TIMEOUT != 0) && (cyc_inc == CNT_W'(TIMEOUT));

        if (clear) begin
            next_state = ST_IDLE;
            cyc_next   = '0;
            chg_next   = '0;
            err_next   = 1'b0;
        end else begin
            unique case (cur_state)
                ST_RUN: begin
                    cyc_next = cyc_inc;
                    if (is_finish) begin
                        next_state = ST_DONE;
                        pulse_next = 1'b1;
                    end else if (is_start) begin
                        // Restart: measure from the newest start mark.
                        cyc_next = '0;
                        chg_next = '0;
                        err_next = 1'b1;
                    end else begin
                        if (accept) begin
                            chg_next = chg_inc;
                        end
                        if (hit_limit) begin
                            next_state = ST_TIMEOUT;
                        end
                    end
                end
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (is_start) begin
                        next_state = ST_RUN;
                        cyc_next   = '0;
                        chg_next   = '0;
                    end else if (is_finish) begin
                        err_next = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
